// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the scratchpad RAM port arbiter.
package ram_port_arbiter_pkg;

    // Largest supported requester count.
    localparam int unsigned NREQ_MAX = 8;

    // Sequencer states: zero sweep after reset, then normal arbitration.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } arb_state_e;

    // Width of the round-robin pointer / grant index (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module rr_pick
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant_c,
    output logic [PW-1:0]   idx_c,
    output logic            any_c
);

    logic [PW-1:0] cand;

    // Walk the requesters from ptr upward (mod NREQ); the first valid one wins.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = PW'((32'(ptr) + k) % NREQ);
            if (!any_c && valid[cand]) begin
                any_c         = 1'b1;
                grant_c[cand] = 1'b1;
                idx_c         = cand;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and sequencer for a single-port synchronous scratchpad.
// Optional post-reset zero sweep, zero-latency grant, one-cycle read response.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 16,
    parameter int unsigned NREQ     = 2,
    parameter int unsigned CLEAR_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               busy,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_din,
    output logic               ram_we,
    input  logic [DW-1:0]      ram_dout
);

    localparam int unsigned PW = ptr_width(NREQ);
    // One extra bit so the terminal sweep address never aliases a wrapped count.
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CLR_LAST = {1'b0, {AW{1'b1}}};

    arb_state_e        state_q, state_d;
    logic [CW-1:0]     clr_q, clr_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [AW-1:0]     addr_q;
    logic [NREQ-1:0]   rsp_q, rsp_d;

    logic [NREQ-1:0]   pick_grant;
    logic [PW-1:0]     pick_idx;
    logic              pick_any;

    logic [AW-1:0]     addr_a  [NREQ];
    logic [DW-1:0]     wdata_a [NREQ];

    // Unpack the per-requester address and write-data slices.
    for (genvar i = 0; i < NREQ; i++) begin : g_split
        assign addr_a[i]  = req_addr[i*AW +: AW];
        assign wdata_a[i] = req_wdata[i*DW +: DW];
    end

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .valid   (req_valid),
        .ptr     (ptr_q),
        .grant_c (pick_grant),
        .idx_c   (pick_idx),
        .any_c   (pick_any)
    );

    // Next-state, RAM port mux and grant; nothing is granted or written while rst is high.
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        ptr_d     = ptr_q;
        rsp_d     = '0;
        req_ready = '0;
        ram_we    = 1'b0;
        ram_din   = '0;
        ram_addr  = addr_q;
        if (rst) begin
            ram_addr = '0;
        end else if (state_q == ST_CLEAR) begin
            ram_we   = 1'b1;
            ram_addr = clr_q[AW-1:0];
            clr_d    = clr_q + CW'(1);
            if (clr_q == CLR_LAST) begin
                state_d = ST_RUN;
            end
        end else if (pick_any) begin
            req_ready = pick_grant;
            ram_we    = req_we[pick_idx];
            ram_addr  = addr_a[pick_idx];
            ram_din   = wdata_a[pick_idx];
            rsp_d     = req_we[pick_idx] ? '0 : pick_grant;
            ptr_d     = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
        end
    end

    // State, sweep counter, pointer, held address and response pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;
            clr_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            ptr_q   <= ptr_d;
            addr_q  <= ram_addr;
            rsp_q   <= rsp_d;
        end
    end

    // A response in flight when reset arrives is dropped.
    assign rsp_valid = rsp_q & ~{NREQ{rst}};
    assign rsp_data  = ram_dout;
    assign busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter (AW=4, DW=16, NREQ=2) with a behavioural RAM.
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;
    logic [3:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [15:0] ram_dout;
    logic        ram_fill;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  we;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  rdy;
    } vec_t;

    typedef struct {
        logic [1:0]  v;
        logic [15:0] d;
    } rsp_t;

    rsp_t        q[$];
    logic [15:0] mdl [16];
    logic [15:0] ram [16];
    logic [3:0]  last_addr;
    int          total;
    int          bad;
    vec_t        tbl [19];

    ram_port_arbiter #(
        .AW       (4),
        .DW       (16),
        .NREQ     (2),
        .CLEAR_EN (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM, registered read, optional garbage fill.
    always_ff @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 16; i++) ram[i] <= 16'hDEAD;
        end else if (ram_we) begin
            ram[ram_addr] <= ram_din;
        end
        ram_dout <= ram[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] we,
                                input logic [3:0] a0, input logic [3:0] a1,
                                input logic [15:0] d0, input logic [15:0] d1,
                                input logic [1:0] rdy);
        vec_t t;
        t.v = v; t.we = we; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1; t.rdy = rdy;
        return t;
    endfunction

    // One RUN cycle: drive, compare grant/port/response, push next response.
    task automatic step(input vec_t t);
        rsp_t        e;
        logic        gi;
        logic [3:0]  ea;
        logic [15:0] ed;
        req_valid = t.v;
        req_we    = t.we;
        req_addr  = {t.a1, t.a0};
        req_wdata = {t.d1, t.d0};
        @(negedge clk);
        if (q.size() > 0) e = q.pop_front();
        else e = '{2'b00, 16'h0};
        chk("rsp_valid", 32'(rsp_valid), 32'(e.v));
        if (e.v != 2'b00) chk("rsp_data", 32'(rsp_data), 32'(e.d));
        chk("req_ready", 32'(req_ready), 32'(t.rdy));
        chk("busy_run", 32'(busy), 32'd0);
        if (t.rdy != 2'b00) begin
            gi = t.rdy[1];
            ea = gi ? t.a1 : t.a0;
            ed = gi ? t.d1 : t.d0;
            chk("ram_addr", 32'(ram_addr), 32'(ea));
            chk("ram_we", 32'(ram_we), 32'(t.we[gi]));
            if (t.we[gi]) begin
                chk("ram_din", 32'(ram_din), 32'(ed));
                mdl[ea] = ed;
                q.push_back('{2'b00, 16'h0});
            end else begin
                q.push_back('{t.rdy, mdl[ea]});
            end
            last_addr = ea;
        end else begin
            chk("idle_we", 32'(ram_we), 32'd0);
            chk("idle_addr", 32'(ram_addr), 32'(last_addr));
            q.push_back('{2'b00, 16'h0});
        end
        @(posedge clk);
        #1;
    endtask

    // One reset cycle with requests withdrawn.
    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        req_we = 2'b00;
        #1;
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        foreach (mdl[i]) mdl[i] = 16'h0;
        chk("rst_busy", 32'(busy), 32'd1);
    endtask

    // Follow the zero sweep; cut >= 0 stops at that address mid-cycle.
    task automatic sweep(input int cut);
        req_valid = 2'b11;
        req_addr  = 8'h21;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("clr_busy", 32'(busy), 32'd1);
            chk("clr_we", 32'(ram_we), 32'd1);
            chk("clr_addr", 32'(ram_addr), 32'(i));
            chk("clr_din", 32'(ram_din), 32'd0);
            chk("clr_ready", 32'(req_ready), 32'd0);
            chk("clr_rsp", 32'(rsp_valid), 32'd0);
            if (i == cut) return;
            @(posedge clk);
            #1;
        end
        chk("busy_fall", 32'(busy), 32'd0);
        req_valid = 2'b00;
        last_addr = 4'hF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        ram_fill = 1'b1;
        req_valid = 2'b00;
        req_we = 2'b00;
        req_addr = 8'h0;
        req_wdata = 32'h0;
        last_addr = 4'h0;
        @(posedge clk);
        #1;
        ram_fill = 1'b0;

        do_reset();
        sweep(-1);

        // Single requester, contention, cross-requester ordering, idle/hold.
        tbl[0]  = mk(2'b01, 2'b00, 4'd7, 4'd0, 16'h0,    16'h0,    2'b01);
        tbl[1]  = mk(2'b01, 2'b01, 4'd3, 4'd0, 16'hBEEF, 16'h0,    2'b01);
        tbl[2]  = mk(2'b01, 2'b00, 4'd3, 4'd0, 16'h0,    16'h0,    2'b01);
        tbl[3]  = mk(2'b10, 2'b00, 4'd0, 4'd2, 16'h0,    16'h0,    2'b10);
        tbl[4]  = mk(2'b11, 2'b00, 4'd1, 4'd2, 16'h0,    16'h0,    2'b01);
        tbl[5]  = mk(2'b11, 2'b00, 4'd1, 4'd2, 16'h0,    16'h0,    2'b10);
        tbl[6]  = mk(2'b11, 2'b00, 4'd1, 4'd2, 16'h0,    16'h0,    2'b01);
        tbl[7]  = mk(2'b11, 2'b00, 4'd1, 4'd2, 16'h0,    16'h0,    2'b10);
        tbl[8]  = mk(2'b10, 2'b10, 4'd0, 4'd5, 16'h0,    16'h1234, 2'b10);
        tbl[9]  = mk(2'b01, 2'b00, 4'd5, 4'd0, 16'h0,    16'h0,    2'b01);
        tbl[10] = mk(2'b00, 2'b00, 4'd9, 4'd9, 16'h0,    16'h0,    2'b00);
        tbl[11] = mk(2'b00, 2'b11, 4'd9, 4'd9, 16'h0,    16'h0,    2'b00);
        tbl[12] = mk(2'b00, 2'b00, 4'd9, 4'd9, 16'h0,    16'h0,    2'b00);
        tbl[13] = mk(2'b11, 2'b11, 4'd8, 4'd9, 16'h1111, 16'h2222, 2'b10);
        tbl[14] = mk(2'b01, 2'b01, 4'd8, 4'd9, 16'h1111, 16'h2222, 2'b01);
        tbl[15] = mk(2'b00, 2'b00, 4'd8, 4'd9, 16'h0,    16'h0,    2'b00);
        tbl[16] = mk(2'b11, 2'b00, 4'd8, 4'd9, 16'h0,    16'h0,    2'b10);
        tbl[17] = mk(2'b01, 2'b00, 4'd8, 4'd0, 16'h0,    16'h0,    2'b01);
        tbl[18] = mk(2'b00, 2'b00, 4'd0, 4'd0, 16'h0,    16'h0,    2'b00);
        for (int i = 0; i < 19; i++) step(tbl[i]);

        // Reset with a read in flight: its response must never appear.
        step(mk(2'b01, 2'b00, 4'd3, 4'd0, 16'h0, 16'h0, 2'b01));
        do_reset();
        sweep(-1);
        step(mk(2'b01, 2'b00, 4'd3, 4'd0, 16'h0, 16'h0, 2'b01));
        step(mk(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b00));

        // Reset in the middle of the sweep restarts it from address 0.
        do_reset();
        sweep(9);
        do_reset();
        sweep(-1);
        step(mk(2'b01, 2'b00, 4'd7, 4'd0, 16'h0, 16'h0, 2'b01));
        step(mk(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter and sequencer for the single-port synchronous `ram_sim` scratchpad. It lets NREQ requesters (for example a filter loader, an ifmap loader and the PE-array reader) share the single RAM port through a valid/ready handshake per requester. It also runs an optional post-reset clear sweep that zeroes the whole memory before any request is accepted. It sits between the requesters and the RAM's addr/din/we/dout pins.

## Interface
Parameters:
- `AW`, 16, RAM address width; the RAM depth is 2^AW.
- `DW`, 16, RAM data width.
- `NREQ`, 2, number of requesters; valid range 2..8.
- `CLEAR_EN`, 1, enables the post-reset zero sweep (1 = on, 0 = off).

Ports:
- `clk`  in  1  single clock for the block and the RAM.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit is high in any cycle.
- `req_we`  in  NREQ  per-requester write enable (1 = write, 0 = read).
- `req_addr`  in  NREQ*AW  packed addresses; requester i uses slice [i*AW +: AW].
- `req_wdata`  in  NREQ*DW  packed write data; requester i uses slice [i*DW +: DW].
- `rsp_valid`  out  NREQ  one-hot read-response valid.
- `rsp_data`  out  DW  shared read-response data bus.
- `busy`  out  1  high while the clear sweep is running.
- `ram_addr`  out  AW  to RAM `addr`.
- `ram_din`  out  DW  to RAM `din`.
- `ram_we`  out  1  to RAM `we`.
- `ram_dout`  in  DW  from RAM `dout`; registered, valid one cycle after the address.

## Operation
- FSM states: CLEAR and RUN.
  - Reset enters CLEAR if CLEAR_EN=1, otherwise RUN.
  - CLEAR → RUN after the write to address 2^AW-1.
- CLEAR state:
  - drives ram_we=1, ram_din=0 and ram_addr=clear counter.
  - The counter starts at 0 and increments by 1 per cycle.
  - req_ready=0, busy=1 for the whole sweep.
- RUN state, arbitration is combinational each cycle:
  - The winner is the first requester with req_valid=1, searching from the round-robin pointer `ptr` upward modulo NREQ.
  - req_ready is set only for the winner.
  - ram_addr, ram_we and ram_din carry the winner's slices.
  - With no valid request: ram_we=0, ram_addr holds its previous value, no response.
- Pointer update: on a grant to requester i, ptr ← (i+1) mod NREQ. Without a grant, ptr is unchanged.
- Handshake rules:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - Once a requester asserts req_valid, it holds valid and a stable payload until the transfer.
  - req_valid must not depend on req_ready.
- Reads produce a response; writes produce none.
  - A read granted in cycle T gives rsp_valid[i]=1 in T+1, with rsp_data=ram_dout.
  - No response backpressure: the requester must take the data in that cycle.
- Ordering: a write in T followed by a read of the same address in T+1 returns the new data. This holds even across requesters.
- Reset mid-operation:
  - Any pending response is dropped (rsp_valid=0).
  - The clear sweep restarts at address 0.
  - ptr is set to 0.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, busy=CLEAR_EN.
  - ram_we=0 during the reset cycle.
  - ram_addr=0, rsp_data don't-care, ptr=0, clear counter=0.
- The grant is decided in the same cycle as the request: zero added cycles of request latency.
- Read latency is 1 cycle from the handshake to rsp_valid.
- Sustained throughput is one access per cycle in aggregate.
- Each continuously-requesting requester is granted at least once every NREQ cycles.
- The clear sweep takes exactly 2^AW cycles. busy falls in the first RUN cycle, and req_ready can be high in that same cycle.
- The clear counter is AW+1 bits wide so that the terminal address is detected without wrap-around ambiguity.

## Structure
- Shared package: FSM state enum (CLEAR, RUN), NREQ upper bound, and the pointer width function clog2(NREQ).
- One sub-module, `rr_pick`: a combinational round-robin priority picker. It takes the valid vector and ptr, and returns a one-hot grant plus a grant index.
- The top level holds:
  - the FSM and the clear counter,
  - ptr,
  - the response pipeline register (rsp_valid one-hot, delayed one cycle),
  - the RAM port muxing.

## Test plan
Use AW=4, DW=16, NREQ=2.
- Clear sweep, CLEAR_EN=1: release rst → busy=1 for 16 cycles with ram_we=1 and ram_addr stepping 0..15. A read of address 7 issued afterwards returns 0x0000.
- Single requester: req0 writes 0xBEEF to addr 3 in cycle T, then reads addr 3 in T+1 → rsp_valid=2'b01 in T+2 with rsp_data=0xBEEF.
- Contention:
  - Both requesters hold valid reads (addrs 1 and 2) for 4 cycles starting at ptr=0 → grants alternate 0,1,0,1.
  - rsp_valid alternates 01,10,01,10, each one cycle after the corresponding grant.
- Cross-requester ordering: req1 writes 0x1234 to addr 5 in T; req0 reads addr 5 in T+1 → req0 receives 0x1234.
- Mid-sweep reset: assert rst for 1 cycle at clear address 9 → the sweep restarts at 0 and busy stays high for 16 more cycles. Mid-run reset with a read outstanding → no rsp_valid afterwards.
- Idle and hold: no valid requests for 3 cycles → ram_we=0, ptr unchanged, no responses. A held req_valid with stable payload is granted exactly once.
